// File: rtl/gelato_rf_arbiter.sv
// gelato_rf_arbiter: register-file read arbiter between the operand collector
// and the register banks. A batch of operand read requests is latched when the
// arbiter is idle. Each cycle, every bank that is not being written back
// receives at most one read, chosen round-robin among the slots that map to it.
// Each granted read comes back one cycle later as a response lane tagged with
// the collector index and the operand index.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   batch handshake (ready only while idle)
//   req_entry_valid       per-entry valid
//   req_warp_num          per-entry warp number
//   req_reg_num           per-slot register number (slot = entry*R + operand)
//   req_reg_valid         per-slot "needs a read"
//   req_collector_num     per-entry collector index, echoed in the response
//   wb_write              per-bank write-back in progress (blocks reads)
//   bank_rd_en/warp/reg   per-bank read strobe and address
//   bank_rd_data          per-bank read data, one cycle after bank_rd_en
//   resp_valid            any response lane active
//   resp_data_valid       per-lane response valid
//   resp_collector_index  per-lane collector index
//   resp_reg_index        per-lane operand index
//   resp_data             per-lane operand data (bank_rd_data passed through)
module gelato_rf_arbiter #(
  parameter int unsigned COLLECTOR_SIZE = 4,
  parameter int unsigned RS_INDEX       = 3,
  parameter int unsigned BANK_NUM       = 4,
  parameter int unsigned WARP_W         = 5,
  parameter int unsigned REG_W          = 5,
  parameter int unsigned COLL_W         = 2,
  parameter int unsigned RS_W           = 2,
  parameter int unsigned DATA_W         = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [COLLECTOR_SIZE-1:0]             req_entry_valid,
  input  logic [COLLECTOR_SIZE*WARP_W-1:0]      req_warp_num,
  input  logic [COLLECTOR_SIZE*RS_INDEX*REG_W-1:0] req_reg_num,
  input  logic [COLLECTOR_SIZE*RS_INDEX-1:0]    req_reg_valid,
  input  logic [COLLECTOR_SIZE*COLL_W-1:0]      req_collector_num,
  input  logic [BANK_NUM-1:0]                   wb_write,
  output logic [BANK_NUM-1:0]                   bank_rd_en,
  output logic [BANK_NUM*WARP_W-1:0]            bank_rd_warp,
  output logic [BANK_NUM*REG_W-1:0]             bank_rd_reg,
  input  logic [BANK_NUM*DATA_W-1:0]            bank_rd_data,
  output logic                                  resp_valid,
  output logic [BANK_NUM-1:0]                   resp_data_valid,
  output logic [BANK_NUM*COLL_W-1:0]            resp_collector_index,
  output logic [BANK_NUM*RS_W-1:0]              resp_reg_index,
  output logic [BANK_NUM*DATA_W-1:0]            resp_data
);

  localparam int unsigned SLOTS  = COLLECTOR_SIZE * RS_INDEX;
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  // BANK_NUM is a power of two, at least 2
  localparam int unsigned BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [SLOTS-1:0]    pending, pending_next, grant_mask;
  logic [WARP_W-1:0]   slot_warp [SLOTS];
  logic [REG_W-1:0]    slot_reg  [SLOTS];
  logic [COLL_W-1:0]   slot_coll [SLOTS];
  logic [BANK_W-1:0]   slot_bank [SLOTS];
  logic [SLOT_W-1:0]   ptr       [BANK_NUM];
  logic [BANK_NUM-1:0] grant;
  logic [SLOT_W-1:0]   grant_slot [BANK_NUM];
  logic [SLOT_W-1:0]   idx;

  logic [BANK_NUM-1:0]        resp_vld_q;
  logic [BANK_NUM*COLL_W-1:0] resp_coll_q;
  logic [BANK_NUM*RS_W-1:0]   resp_rs_q;

  // Bank select: low bits of reg+warp, carries out of those bits dropped.
  always_comb begin
    for (int unsigned s = 0; s < SLOTS; s++) begin
      slot_bank[s] = slot_reg[s][BANK_W-1:0] + slot_warp[s][BANK_W-1:0];
    end
  end

  // Per-bank round-robin search starting at ptr[b]; a bank under write-back
  // is skipped entirely so its pending slots and pointer are left untouched.
  always_comb begin
    grant      = '0;
    grant_mask = '0;
    idx        = '0;
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      grant_slot[b] = '0;
    end
    if (state == ARB) begin
      for (int unsigned b = 0; b < BANK_NUM; b++) begin
        if (!wb_write[b]) begin
          for (int unsigned k = 0; k < SLOTS; k++) begin
            idx = SLOT_W'((32'(ptr[b]) + k) % SLOTS);
            if (!grant[b] && pending[idx] && (slot_bank[idx] == BANK_W'(b))) begin
              grant[b]        = 1'b1;
              grant_slot[b]   = idx;
              grant_mask[idx] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    bank_rd_warp = '0;
    bank_rd_reg  = '0;
    for (int unsigned b = 0; b < BANK_NUM; b++) begin
      if (grant[b]) begin
        bank_rd_warp[b*WARP_W +: WARP_W] = slot_warp[grant_slot[b]];
        bank_rd_reg[b*REG_W +: REG_W]    = slot_reg[grant_slot[b]];
      end
    end
  end

  assign bank_rd_en = grant;

  always_comb begin
    state_next   = state;
    pending_next = pending;
    case (state)
      IDLE: begin
        if (req_valid) begin
          for (int unsigned e = 0; e < COLLECTOR_SIZE; e++) begin
            for (int unsigned r = 0; r < RS_INDEX; r++) begin
              pending_next[e*RS_INDEX+r] = req_entry_valid[e] & req_reg_valid[e*RS_INDEX+r];
            end
          end
          state_next = (pending_next != '0) ? ARB : IDLE;
        end
      end
      ARB: begin
        pending_next = pending & ~grant_mask;
        if (pending_next == '0) state_next = DRAIN;
      end
      DRAIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= '0;
      resp_vld_q  <= '0;
      resp_coll_q <= '0;
      resp_rs_q   <= '0;
      for (int unsigned b = 0; b < BANK_NUM; b++) begin
        ptr[b] <= '0;
      end
    end else begin
      state      <= state_next;
      pending    <= pending_next;
      resp_vld_q <= grant;
      for (int unsigned b = 0; b < BANK_NUM; b++) begin
        if (grant[b]) begin
          ptr[b] <= SLOT_W'((32'(grant_slot[b]) + 32'd1) % SLOTS);
          resp_coll_q[b*COLL_W +: COLL_W] <= slot_coll[grant_slot[b]];
          resp_rs_q[b*RS_W +: RS_W]       <= RS_W'(32'(grant_slot[b]) % RS_INDEX);
        end else begin
          resp_coll_q[b*COLL_W +: COLL_W] <= '0;
          resp_rs_q[b*RS_W +: RS_W]       <= '0;
        end
      end
    end
  end

  // Request payload is only consumed while pending bits are set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      for (int unsigned e = 0; e < COLLECTOR_SIZE; e++) begin
        for (int unsigned r = 0; r < RS_INDEX; r++) begin
          slot_warp[e*RS_INDEX+r] <= req_warp_num[e*WARP_W +: WARP_W];
          slot_reg[e*RS_INDEX+r]  <= req_reg_num[(e*RS_INDEX+r)*REG_W +: REG_W];
          slot_coll[e*RS_INDEX+r] <= req_collector_num[e*COLL_W +: COLL_W];
        end
      end
    end
  end

  assign req_ready            = (state == IDLE);
  assign resp_data_valid      = resp_vld_q;
  assign resp_valid           = |resp_vld_q;
  assign resp_collector_index = resp_coll_q;
  assign resp_reg_index       = resp_rs_q;
  assign resp_data            = bank_rd_data;

endmodule

// File: tb/tb_gelato_rf_arbiter.sv
// Testbench for gelato_rf_arbiter: directed scenarios plus a randomized run
// checked against a slot-level behavioural model of the arbiter.
module tb_gelato_rf_arbiter;
  localparam int C = 4, R = 3, B = 4, S = C * R;
  localparam int WW = 5, RGW = 5, CW = 2, RSW = 2, DW = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, req_valid, req_ready, resp_valid;
  logic [C-1:0]      req_entry_valid;
  logic [C*WW-1:0]   req_warp_num;
  logic [S*RGW-1:0]  req_reg_num;
  logic [S-1:0]      req_reg_valid;
  logic [C*CW-1:0]   req_collector_num;
  logic [B-1:0]      wb_write, bank_rd_en, resp_data_valid;
  logic [B*WW-1:0]   bank_rd_warp;
  logic [B*RGW-1:0]  bank_rd_reg;
  logic [B*DW-1:0]   bank_rd_data, resp_data;
  logic [B*CW-1:0]   resp_collector_index;
  logic [B*RSW-1:0]  resp_reg_index;

  gelato_rf_arbiter #(
    .COLLECTOR_SIZE(C), .RS_INDEX(R), .BANK_NUM(B), .WARP_W(WW),
    .REG_W(RGW), .COLL_W(CW), .RS_W(RSW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_entry_valid(req_entry_valid), .req_warp_num(req_warp_num),
    .req_reg_num(req_reg_num), .req_reg_valid(req_reg_valid),
    .req_collector_num(req_collector_num), .wb_write(wb_write),
    .bank_rd_en(bank_rd_en), .bank_rd_warp(bank_rd_warp), .bank_rd_reg(bank_rd_reg),
    .bank_rd_data(bank_rd_data), .resp_valid(resp_valid),
    .resp_data_valid(resp_data_valid), .resp_collector_index(resp_collector_index),
    .resp_reg_index(resp_reg_index), .resp_data(resp_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 arbitrating, 2 draining
  int       m_state = 0;
  bit       m_pend [S];
  int       m_warp [C];
  int       m_reg  [S];
  int       m_coll [C];
  int       m_ptr  [B];
  bit       m_rv   [B];
  int       m_rc   [B];
  int       m_rr   [B];
  bit       e_ready;
  logic [B-1:0] e_en;
  int       e_slot [B];

  task automatic model_eval();
    int s;
    e_ready = (m_state == 0);
    e_en = '0;
    for (int b = 0; b < B; b++) begin
      e_slot[b] = 0;
      if (m_state == 1 && !wb_write[b]) begin
        for (int k = 0; k < S; k++) begin
          s = (m_ptr[b] + k) % S;
          if (!e_en[b] && m_pend[s] && ((m_reg[s] + m_warp[s / R]) % B) == b) begin
            e_en[b] = 1'b1;
            e_slot[b] = s;
          end
        end
      end
    end
  endtask

  task automatic model_update();
    bit any;
    if (!rst_n) begin
      m_state = 0;
      for (int s = 0; s < S; s++) m_pend[s] = 1'b0;
      for (int b = 0; b < B; b++) begin
        m_ptr[b] = 0; m_rv[b] = 1'b0; m_rc[b] = 0; m_rr[b] = 0;
      end
      return;
    end
    for (int b = 0; b < B; b++) begin
      m_rv[b] = e_en[b];
      m_rc[b] = e_en[b] ? m_coll[e_slot[b] / R] : 0;
      m_rr[b] = e_en[b] ? e_slot[b] % R : 0;
    end
    any = 1'b0;
    case (m_state)
      0: if (req_valid) begin
        for (int e = 0; e < C; e++) begin
          m_warp[e] = int'(req_warp_num[e*WW +: WW]);
          m_coll[e] = int'(req_collector_num[e*CW +: CW]);
          for (int r = 0; r < R; r++) begin
            m_reg[e*R+r]  = int'(req_reg_num[(e*R+r)*RGW +: RGW]);
            m_pend[e*R+r] = req_entry_valid[e] && req_reg_valid[e*R+r];
            any |= m_pend[e*R+r];
          end
        end
        if (any) m_state = 1;
      end
      1: begin
        for (int b = 0; b < B; b++) begin
          if (e_en[b]) begin
            m_pend[e_slot[b]] = 1'b0;
            m_ptr[b] = (e_slot[b] + 1) % S;
          end
        end
        for (int s = 0; s < S; s++) any |= m_pend[s];
        if (!any) m_state = 2;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
  endtask

  task automatic rand_data();
    for (int i = 0; i < B * DW / 32; i++) bank_rd_data[i*32 +: 32] = $urandom;
  endtask

  task automatic clear_req();
    req_valid = 1'b0; req_entry_valid = '0; req_warp_num = '0; req_reg_num = '0;
    req_reg_valid = '0; req_collector_num = '0; wb_write = '0;
    rand_data();
  endtask

  task automatic set_op(input int e, input int r, input int rg);
    req_entry_valid[e] = 1'b1;
    req_reg_valid[e*R+r] = 1'b1;
    req_reg_num[(e*R+r)*RGW +: RGW] = RGW'(rg);
  endtask

  task automatic test_reset();
    @(negedge clk); clear_req(); rst_n = 1'b0; req_valid = 1'b1; tick();
    @(negedge clk); tick();
    @(negedge clk); rst_n = 1'b1; req_valid = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if (bank_rd_en !== 4'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0000", bank_rd_en); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++; if (resp_data_valid !== 4'b0) begin errors++; $display("FAIL reset_rdv got %b exp 0000", resp_data_valid); end
    checks++; if (resp_collector_index !== 8'h0 || resp_reg_index !== 8'h0) begin
      errors++; $display("FAIL reset_meta got %h/%h exp 00/00", resp_collector_index, resp_reg_index); end
    tick();
  endtask

  task automatic test_basic();
    @(negedge clk); clear_req();
    set_op(0, 0, 1); set_op(0, 1, 2); set_op(0, 2, 3);
    req_collector_num[1:0] = 2'd2; req_valid = 1'b1; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", req_ready); end
    tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (bank_rd_en !== 4'b1110) begin errors++; $display("FAIL basic_en got %b exp 1110", bank_rd_en); end
    checks++; if (bank_rd_reg[5 +: 15] !== {5'd3, 5'd2, 5'd1} || bank_rd_warp[5 +: 15] !== 15'd0) begin
      errors++; $display("FAIL basic_addr got reg %h warp %h exp reg 3/2/1 warp 0", bank_rd_reg, bank_rd_warp); end
    tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (resp_data_valid !== 4'b1110 || resp_valid !== 1'b1) begin
      errors++; $display("FAIL basic_rdv got %b/%b exp 1110/1", resp_data_valid, resp_valid); end
    checks++; if (resp_collector_index !== 8'b10_10_10_00) begin
      errors++; $display("FAIL basic_coll got %b exp 10101000", resp_collector_index); end
    checks++; if (resp_reg_index !== 8'b10_01_00_00) begin
      errors++; $display("FAIL basic_rsidx got %b exp 10010000", resp_reg_index); end
    checks++; if (resp_data[DW +: DW] !== bank_rd_data[DW +: DW]) begin
      errors++; $display("FAIL basic_data got %h exp %h", resp_data[DW +: 32], bank_rd_data[DW +: 32]); end
    checks++; if (req_ready !== 1'b0 || bank_rd_en !== 4'b0) begin
      errors++; $display("FAIL basic_drain got ready %b en %b exp 0 0000", req_ready, bank_rd_en); end
    tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL basic_idle got ready %b resp %b exp 1 0", req_ready, resp_valid); end
    tick();
  endtask

  task automatic test_conflict();
    @(negedge clk); clear_req();
    set_op(0, 0, 0); set_op(0, 1, 4); set_op(0, 2, 8);
    req_collector_num[1:0] = 2'd1; req_valid = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clear_req(); #1;
      checks++; if (bank_rd_en !== 4'b0001 || bank_rd_reg[4:0] !== 5'(i * 4)) begin
        errors++; $display("FAIL conflict_grant%0d got en %b reg %0d exp 0001 %0d", i, bank_rd_en, bank_rd_reg[4:0], i * 4); end
      if (i > 0) begin
        checks++; if (resp_data_valid !== 4'b0001 || resp_reg_index[1:0] !== 2'(i - 1)) begin
          errors++; $display("FAIL conflict_resp%0d got %b idx %0d exp 0001 %0d", i, resp_data_valid, resp_reg_index[1:0], i - 1); end
      end
      tick();
    end
    @(negedge clk); clear_req(); #1;
    checks++; if (req_ready !== 1'b0 || resp_reg_index[1:0] !== 2'd2 || resp_collector_index[1:0] !== 2'd1) begin
      errors++; $display("FAIL conflict_last got ready %b idx %0d coll %0d exp 0 2 1", req_ready, resp_reg_index[1:0], resp_collector_index[1:0]); end
    tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL conflict_ready got %b exp 1", req_ready); end
    tick();
  endtask

  task automatic test_wb();
    @(negedge clk); clear_req();
    set_op(0, 0, 1); set_op(0, 1, 2); set_op(0, 2, 3);
    req_collector_num[1:0] = 2'd2; req_valid = 1'b1; tick();
    @(negedge clk); clear_req(); wb_write = 4'b0100; #1;
    checks++; if (bank_rd_en !== 4'b1010) begin errors++; $display("FAIL wb_arb1 got %b exp 1010", bank_rd_en); end
    tick();
    @(negedge clk); clear_req(); wb_write = 4'b0100; #1;
    checks++; if (bank_rd_en !== 4'b0000 || resp_data_valid !== 4'b1010) begin
      errors++; $display("FAIL wb_arb2 got en %b rdv %b exp 0000 1010", bank_rd_en, resp_data_valid); end
    tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (bank_rd_en !== 4'b0100 || bank_rd_reg[10 +: 5] !== 5'd2) begin
      errors++; $display("FAIL wb_arb3 got en %b reg %0d exp 0100 2", bank_rd_en, bank_rd_reg[10 +: 5]); end
    tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (resp_data_valid !== 4'b0100 || resp_reg_index[4 +: 2] !== 2'd1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL wb_resp got rdv %b idx %0d ready %b exp 0100 1 0", resp_data_valid, resp_reg_index[4 +: 2], req_ready); end
    tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wb_ready got %b exp 1", req_ready); end
    tick();
  endtask

  task automatic test_round_robin();
    @(negedge clk); clear_req(); rst_n = 1'b0; tick();
    @(negedge clk); rst_n = 1'b1; set_op(0, 0, 0); req_valid = 1'b1; tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (bank_rd_en !== 4'b0001) begin errors++; $display("FAIL rr_a_grant got %b exp 0001", bank_rd_en); end
    tick();
    @(negedge clk); clear_req(); tick();
    @(negedge clk); clear_req();
    set_op(0, 0, 0); set_op(1, 0, 4);
    req_collector_num = {2'd0, 2'd0, 2'd1, 2'd0}; req_valid = 1'b1; tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (bank_rd_en !== 4'b0001 || bank_rd_reg[4:0] !== 5'd4) begin
      errors++; $display("FAIL rr_b_first got en %b reg %0d exp 0001 4", bank_rd_en, bank_rd_reg[4:0]); end
    tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (bank_rd_reg[4:0] !== 5'd0 || resp_collector_index[1:0] !== 2'd1) begin
      errors++; $display("FAIL rr_b_second got reg %0d coll %0d exp 0 1", bank_rd_reg[4:0], resp_collector_index[1:0]); end
    tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (resp_data_valid !== 4'b0001 || resp_collector_index[1:0] !== 2'd0) begin
      errors++; $display("FAIL rr_b_resp got rdv %b coll %0d exp 0001 0", resp_data_valid, resp_collector_index[1:0]); end
    tick();
  endtask

  task automatic test_empty();
    @(negedge clk); clear_req(); req_valid = 1'b1; req_entry_valid = 4'hf; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL empty_accept got %b exp 1", req_ready); end
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); clear_req(); #1;
      checks++; if (req_ready !== 1'b1 || bank_rd_en !== 4'b0) begin
        errors++; $display("FAIL empty_idle%0d got ready %b en %b exp 1 0000", i, req_ready, bank_rd_en); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); clear_req();
    set_op(0, 0, 0); set_op(0, 1, 4); set_op(0, 2, 8); set_op(1, 0, 12);
    req_collector_num = {2'd0, 2'd0, 2'd3, 2'd0}; req_valid = 1'b1; tick();
    @(negedge clk); clear_req(); tick();
    @(negedge clk); clear_req(); rst_n = 1'b0; tick();
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (bank_rd_en !== 4'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_state got en %b resp %b ready %b exp 0000 0 1", bank_rd_en, resp_valid, req_ready); end
    set_op(0, 0, 0); set_op(1, 0, 4);
    req_collector_num = {2'd0, 2'd0, 2'd2, 2'd1}; req_valid = 1'b1; tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (bank_rd_en !== 4'b0001 || bank_rd_reg[4:0] !== 5'd0) begin
      errors++; $display("FAIL rstmid_ptr got en %b reg %0d exp 0001 0", bank_rd_en, bank_rd_reg[4:0]); end
    tick();
    @(negedge clk); clear_req(); #1;
    checks++; if (bank_rd_reg[4:0] !== 5'd4 || resp_collector_index[1:0] !== 2'd1) begin
      errors++; $display("FAIL rstmid_second got reg %0d coll %0d exp 4 1", bank_rd_reg[4:0], resp_collector_index[1:0]); end
    tick();
    @(negedge clk); clear_req(); tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 199) != 0);
      req_valid = $urandom_range(0, 1) == 1;
      req_entry_valid = C'($urandom);
      req_warp_num = C*WW'($urandom);
      for (int s = 0; s < S; s++) req_reg_num[s*RGW +: RGW] = RGW'($urandom);
      req_reg_valid = S'($urandom) & S'($urandom | $urandom);
      req_collector_num = C*CW'($urandom);
      for (int b = 0; b < B; b++) wb_write[b] = ($urandom_range(0, 3) == 0);
      rand_data();
      #1;
      model_eval();
      checks++; if (req_ready !== e_ready) begin
        errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, req_ready, e_ready); end
      checks++; if (bank_rd_en !== e_en) begin
        errors++; $display("FAIL rnd_en cyc %0d got %b exp %b", cyc, bank_rd_en, e_en); end
      for (int b = 0; b < B; b++) begin
        if (e_en[b]) begin
          checks++;
          if (bank_rd_warp[b*WW +: WW] !== WW'(m_warp[e_slot[b] / R]) || bank_rd_reg[b*RGW +: RGW] !== RGW'(m_reg[e_slot[b]])) begin
            errors++; $display("FAIL rnd_addr cyc %0d bank %0d got w%0d r%0d exp w%0d r%0d", cyc, b,
              bank_rd_warp[b*WW +: WW], bank_rd_reg[b*RGW +: RGW], m_warp[e_slot[b] / R], m_reg[e_slot[b]]); end
        end
        checks++;
        if (resp_data_valid[b] !== m_rv[b] || resp_collector_index[b*CW +: CW] !== CW'(m_rc[b]) || resp_reg_index[b*RSW +: RSW] !== RSW'(m_rr[b])) begin
          errors++; $display("FAIL rnd_resp cyc %0d lane %0d got v%b c%0d r%0d exp v%b c%0d r%0d", cyc, b, resp_data_valid[b],
            resp_collector_index[b*CW +: CW], resp_reg_index[b*RSW +: RSW], m_rv[b], m_rc[b], m_rr[b]); end
        if (m_rv[b]) begin
          checks++; if (resp_data[b*DW +: DW] !== bank_rd_data[b*DW +: DW]) begin
            errors++; $display("FAIL rnd_data cyc %0d lane %0d got %h exp %h", cyc, b, resp_data[b*DW +: 32], bank_rd_data[b*DW +: 32]); end
        end
      end
      checks++; if (resp_valid !== (m_rv[0] | m_rv[1] | m_rv[2] | m_rv[3])) begin
        errors++; $display("FAIL rnd_resp_valid cyc %0d got %b", cyc, resp_valid); end
      tick();
    end
    @(negedge clk); rst_n = 1'b1; clear_req(); tick();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_req();
    test_reset();
    test_basic();
    test_conflict();
    test_wb();
    test_round_robin();
    test_empty();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
